// File: rtl/mpu_i2c_pkg.sv
// Shared types and constants for the MPU6050 I2C burst reader.
// Holds the FSM state enum, the quarter-phase encoding and MPU6050 register constants.
package mpu_i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR_W,
        S_ACK_A,
        S_REG,
        S_ACK_R,
        S_RSTART,
        S_ADDR_R,
        S_ACK_B,
        S_READ,
        S_MACK,
        S_STOP
    } state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    localparam logic [6:0]  MPU6050_ADDR         = 7'h68;
    localparam logic [7:0]  MPU6050_ACCEL_XOUT_H = 8'h3B;
    localparam int unsigned MPU6050_BURST_LEN    = 14;

    function automatic quarter_t next_quarter(input quarter_t q);
        return quarter_t'(q + 2'd1);
    endfunction

    // SCL is high during the middle two quarters of an ordinary bit slot.
    function automatic logic scl_high_phase(input quarter_t q);
        return (q == Q1) || (q == Q2);
    endfunction

endpackage

// File: rtl/mpu_i2c_tick_gen.sv
// Quarter-period tick divider for the I2C master.
// Counts 0..CLK_DIV-1 while enabled and advances the quarter phase on each tick;
// hold freezes the count so a slave can stretch the SCL high phase.
module mpu_i2c_tick_gen
    import mpu_i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en,
    input  logic     hold,
    output logic     tick,
    output quarter_t q
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !hold && (cnt == CNT_MAX);

    // Divider counter and quarter phase; both cleared whenever the master is idle.
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= '0;
            q   <= Q0;
        end else if (!hold) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                q   <= next_quarter(q);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mpu_i2c_burst_reader.sv
// MPU6050 I2C burst-read master: START, addr+W, register pointer, repeated START,
// addr+R, then len bytes (ACK all but the last, NACK the last), then STOP.
// Build option MPU_I2C_STRETCH_EN: hold the divider in q1 until scl_i reads high.
module mpu_i2c_burst_reader
    import mpu_i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 250,
    parameter logic [6:0]  DEV_ADDR = MPU6050_ADDR,
    parameter int unsigned LEN_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] len,
    inout  wire              sda,
    output logic             scl,
    input  logic             scl_i,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err
);

    state_t           state, state_nxt;
    quarter_t         q;
    logic             tick, stretch_hold, end_bit, sample;
    logic             sda_in, sda_low, scl_drv;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shreg, shreg_nxt, reg_q, reg_q_nxt, rx_data_nxt;
    logic [LEN_W-1:0] bytes_left, bytes_left_nxt;
    logic             rx_valid_nxt, done_nxt, nack_err_nxt;

`ifdef MPU_I2C_STRETCH_EN
    assign stretch_hold = (q == Q1) && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign stretch_hold = 1'b0;
`endif

    mpu_i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state != S_IDLE),
        .hold (stretch_hold),
        .tick (tick),
        .q    (q)
    );

    assign end_bit = tick && (q == Q3);
    assign sample  = tick && (q == Q1);
    assign sda_in  = sda;
    assign sda     = sda_low ? 1'b0 : 1'bz;
    assign scl     = scl_drv;
    assign busy    = (state != S_IDLE);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            reg_q      <= '0;
            bytes_left <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            done       <= 1'b0;
            nack_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            reg_q      <= reg_q_nxt;
            bytes_left <= bytes_left_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            done       <= done_nxt;
            nack_err   <= nack_err_nxt;
        end
    end

    // Next-state and datapath updates; everything advances on the q1/q3 ticks.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        shreg_nxt      = shreg;
        reg_q_nxt      = reg_q;
        bytes_left_nxt = bytes_left;
        rx_data_nxt    = rx_data;
        rx_valid_nxt   = 1'b0;
        done_nxt       = 1'b0;
        nack_err_nxt   = nack_err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    nack_err_nxt = 1'b0;
                    if (len != '0) begin
                        state_nxt      = S_START;
                        reg_q_nxt      = reg_addr;
                        bytes_left_nxt = len;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            S_START: begin
                if (end_bit) begin
                    state_nxt   = S_ADDR_W;
                    shreg_nxt   = {DEV_ADDR, 1'b0};
                    bit_cnt_nxt = '0;
                end
            end
            S_RSTART: begin
                if (end_bit) begin
                    state_nxt   = S_ADDR_R;
                    shreg_nxt   = {DEV_ADDR, 1'b1};
                    bit_cnt_nxt = '0;
                end
            end
            S_ADDR_W, S_REG, S_ADDR_R: begin
                if (end_bit) begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        if (state == S_ADDR_W)  state_nxt = S_ACK_A;
                        else if (state == S_REG) state_nxt = S_ACK_R;
                        else                     state_nxt = S_ACK_B;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        shreg_nxt   = {shreg[6:0], 1'b0};
                    end
                end
            end
            S_ACK_A, S_ACK_R, S_ACK_B: begin
                if (sample && sda_in) nack_err_nxt = 1'b1;
                if (end_bit) begin
                    bit_cnt_nxt = '0;
                    if (nack_err) begin
                        state_nxt = S_STOP;
                    end else if (state == S_ACK_A) begin
                        state_nxt = S_REG;
                        shreg_nxt = reg_q;
                    end else if (state == S_ACK_R) begin
                        state_nxt = S_RSTART;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                if (sample) shreg_nxt = {shreg[6:0], sda_in};
                if (end_bit) begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt  = '0;
                        rx_data_nxt  = shreg;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = S_MACK;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            S_MACK: begin
                if (end_bit) begin
                    bytes_left_nxt = bytes_left - 1'b1;
                    state_nxt      = (bytes_left > LEN_W'(1)) ? S_READ : S_STOP;
                end
            end
            S_STOP: begin
                if (end_bit) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus drive: START/RSTART drop SDA in q2 with SCL high, STOP releases SDA in q2.
    always_comb begin
        scl_drv = 1'b1;
        sda_low = 1'b0;
        case (state)
            S_IDLE: begin
                scl_drv = 1'b1;
            end
            S_START: begin
                scl_drv = (q != Q3);
                sda_low = (q == Q2) || (q == Q3);
            end
            S_RSTART: begin
                scl_drv = scl_high_phase(q);
                sda_low = (q == Q2) || (q == Q3);
            end
            S_STOP: begin
                scl_drv = (q != Q0);
                sda_low = (q == Q0) || (q == Q1);
            end
            S_ADDR_W, S_REG, S_ADDR_R: begin
                scl_drv = scl_high_phase(q);
                sda_low = !shreg[7];
            end
            S_MACK: begin
                scl_drv = scl_high_phase(q);
                sda_low = (bytes_left > LEN_W'(1));
            end
            default: begin
                scl_drv = scl_high_phase(q);
            end
        endcase
    end

endmodule

// File: tb/tb_mpu_i2c_burst_reader.sv
// Self-checking bench for mpu_i2c_burst_reader with a behavioural MPU6050 slave.
module tb_mpu_i2c_burst_reader;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned LIMIT   = 6000;
`ifdef MPU_I2C_STRETCH_EN
    localparam int unsigned STRETCH = 20;
`else
    localparam int unsigned STRETCH = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       reg_addr = '0;
    logic [LEN_W-1:0] len = '0;
    wire              sda;
    logic             scl, scl_i;
    logic [7:0]       rx_data;
    logic             rx_valid, busy, done, nack_err;

    mpu_i2c_burst_reader #(
        .CLK_DIV (CLK_DIV),
        .DEV_ADDR(7'h68),
        .LEN_W   (LEN_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .reg_addr(reg_addr),
        .len     (len),
        .sda     (sda),
        .scl     (scl),
        .scl_i   (scl_i),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .done    (done),
        .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model (bench-side config) ----------------
    logic       slave_en  = 1'b1;
    logic       nack_addr = 1'b0;
    logic [7:0] tx_base   = '0;

    logic        slave_low = 1'b0;
    int unsigned stretch_left = 0;
    logic [7:0]  bus_q[$];
    logic        mack_q[$];
    int unsigned starts = 0, stops = 0, hi_len = 0, hi_n = 0;

    pullup (sda);
    assign sda   = (slave_en && slave_low) ? 1'b0 : 1'bz;
    assign scl_i = scl && (stretch_left == 0);

    logic        prev_scl = 1'b1, prev_sda = 1'b1;
    logic        rd_mode = 1'b0, first = 1'b0, go_read = 1'b0, ignore_fall = 1'b0;
    logic        meas = 1'b0, last_mack = 1'b1;
    logic [7:0]  sh = '0, tx_cur = '0;
    int          bitidx = 0;
    int unsigned tx_idx = 0, start_in_txn = 0, rise_cyc = 0;

    always @(negedge clk) begin
        logic sc, sd;
        sc = scl;
        sd = sda;
        if (stretch_left != 0) stretch_left = stretch_left - 1;
        if (!slave_en) begin
            slave_low    = 1'b0;
            start_in_txn = 0;
            meas         = 1'b0;
        end else if (prev_scl && sc && prev_sda && !sd) begin
            starts++;
            start_in_txn++;
            bitidx      = 0;
            rd_mode     = 1'b0;
            first       = 1'b1;
            go_read     = 1'b0;
            ignore_fall = 1'b1;
            tx_idx      = 0;
            slave_low   = 1'b0;
        end else if (prev_scl && sc && !prev_sda && sd) begin
            stops++;
            start_in_txn = 0;
        end else if (!prev_scl && sc) begin
            rise_cyc = cyc;
            if (start_in_txn == 2 && !rd_mode && first && bitidx == 3) begin
                meas = 1'b1;
                stretch_left = STRETCH;
            end
            if (bitidx < 8) begin
                if (!rd_mode) sh = {sh[6:0], sd};
            end else if (rd_mode) begin
                mack_q.push_back(sd);
                last_mack = sd;
            end
        end else if (prev_scl && !sc) begin
            if (meas) begin
                hi_len = cyc - rise_cyc;
                hi_n++;
                meas = 1'b0;
            end
            if (ignore_fall) begin
                ignore_fall = 1'b0;
            end else begin
                bitidx++;
                if (bitidx == 8) begin
                    if (!rd_mode) begin
                        bus_q.push_back(sh);
                        slave_low = !(nack_addr && first);
                        if (first) go_read = sh[0];
                        first = 1'b0;
                    end else begin
                        slave_low = 1'b0;
                    end
                end else if (bitidx == 9) begin
                    bitidx = 0;
                    if ((!rd_mode && go_read) || (rd_mode && !last_mack)) begin
                        rd_mode   = 1'b1;
                        go_read   = 1'b0;
                        tx_cur    = tx_base + tx_idx[7:0];
                        tx_idx++;
                        slave_low = !tx_cur[7];
                    end else begin
                        slave_low = 1'b0;
                    end
                end else if (rd_mode) begin
                    slave_low = !tx_cur[7 - bitidx];
                end else begin
                    slave_low = 1'b0;
                end
            end
        end
        prev_scl = sc;
        prev_sda = sd;
    end

    // ---------------- checking ----------------
    int unsigned checks = 0, errors = 0;
    int unsigned done_seen = 0, rx_seen = 0;
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock, sampled on the falling edge; received bytes are scored as they appear.
    task automatic step();
        @(negedge clk);
        if (rx_valid) begin
            rx_seen++;
            if (exp_q.size() == 0) chk("rx_unexpected", 1, 0);
            else                   chk("rx_data", rx_data, exp_q.pop_front());
        end
        if (done) done_seen++;
    endtask

    typedef struct {
        logic [7:0]  ra;
        int unsigned ln;
        logic        slave_nack;
        logic [7:0]  base;
        logic        exp_nack;
        int unsigned exp_rx;
    } vec_t;

    vec_t vecs[4];

    task automatic run_txn(input vec_t v);
        int unsigned b0, m0, s0, p0, h0, r0, d0, n;
        b0 = bus_q.size(); m0 = mack_q.size();
        s0 = starts; p0 = stops; h0 = hi_n; r0 = rx_seen; d0 = done_seen;
        nack_addr = v.slave_nack;
        tx_base   = v.base;
        for (int k = 0; k < int'(v.exp_rx); k++) exp_q.push_back(v.base + 8'(k));
        start = 1'b1; reg_addr = v.ra; len = LEN_W'(v.ln);
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        step();
        // Second request mid-transfer with different inputs must be ignored.
        start = 1'b1; reg_addr = 8'hFF; len = LEN_W'(7);
        step();
        start = 1'b0;
        n = 0;
        while (done_seen == d0 && n < LIMIT) begin
            step();
            n++;
        end
        chk("done_seen", done_seen - d0, 1);
        chk("busy_at_done", busy, 0);
        step();
        chk("done_one_cycle", done, 0);
        chk("nack_err", nack_err, v.exp_nack);
        chk("rx_count", rx_seen - r0, v.exp_rx);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("start_count", starts - s0, v.exp_nack ? 1 : 2);
        chk("stop_count", stops - p0, 1);
        chk("bus_bytes", bus_q.size() - b0, v.exp_nack ? 1 : 3);
        if (bus_q.size() > b0) chk("addr_w_byte", bus_q[b0], 8'hD0);
        if (!v.exp_nack && bus_q.size() >= b0 + 3) begin
            chk("reg_byte", bus_q[b0 + 1], v.ra);
            chk("addr_r_byte", bus_q[b0 + 2], 8'hD1);
            chk("scl_high_len", hi_len, 2 * CLK_DIV + STRETCH);
            chk("scl_high_meas", hi_n - h0, 1);
        end
        chk("mack_count", mack_q.size() - m0, v.exp_rx);
        for (int k = 0; k < int'(v.exp_rx); k++)
            if (mack_q.size() > m0 + k)
                chk("master_ack", mack_q[m0 + k], (k == int'(v.exp_rx) - 1) ? 1 : 0);
    endtask

    initial begin
        logic act;
        int unsigned r0, n;
        vecs[0] = '{ra: 8'h3B, ln: 14, slave_nack: 1'b0, base: 8'h00, exp_nack: 1'b0, exp_rx: 14};
        vecs[1] = '{ra: 8'h3B, ln: 14, slave_nack: 1'b1, base: 8'h00, exp_nack: 1'b1, exp_rx: 0};
        vecs[2] = '{ra: 8'h75, ln: 1,  slave_nack: 1'b0, base: 8'hA5, exp_nack: 1'b0, exp_rx: 1};
        vecs[3] = '{ra: 8'h10, ln: 3,  slave_nack: 1'b0, base: 8'h80, exp_nack: 1'b0, exp_rx: 3};

        // Reset state.
        step(); step();
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_nack_err", nack_err, 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // len == 0: no bus activity, done the cycle after start.
        start = 1'b1; len = '0; reg_addr = 8'h3B;
        step();
        start = 1'b0;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        act = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            act |= busy | !scl | !sda;
        end
        chk("len0_idle_bus", act, 0);
        chk("len0_done_once", done, 0);

        // Reset during the third read byte, then a clean transaction.
        r0 = rx_seen;
        nack_addr = 1'b0; tx_base = 8'h00;
        for (int k = 0; k < 14; k++) exp_q.push_back(8'(k));
        start = 1'b1; reg_addr = 8'h3B; len = LEN_W'(14);
        step();
        start = 1'b0;
        n = 0;
        while (rx_seen - r0 < 2 && n < LIMIT) begin
            step();
            n++;
        end
        chk("pre_reset_rx", rx_seen - r0, 2);
        repeat (20) step();
        rst_n = 1'b0; slave_en = 1'b0;
        step();
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_rx_data", rx_data, 0);
        exp_q.delete();
        rst_n = 1'b1;
        step();
        slave_en = 1'b1;
        step();
        run_txn(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
